// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding and the
// padding instruction word that instruction-decode tests also rely on.
package program_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_PLAY    = 3'd1,
        ST_NOP     = 3'd2,
        ST_RESTART = 3'd3,
        ST_RUN     = 3'd4
    } loader_state_e;

endpackage : program_loader_pkg

// File: rtl/program_loader_word_buffer.sv
// Program word store: synchronous write, combinational read, so a word
// written on an edge is visible on the read port in the following cycle.
module loader_word_buffer
    import program_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WORD_W-1:0] o_rd_data
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Contents deliberately survive reset; only the loader's count says what is valid.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : loader_word_buffer

// File: rtl/program_loader.sv
// Boot loader in front of top_level: packs host bytes into 16-bit words,
// buffers the program, replays it through we_ins/load, then restarts the CPU.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter bit          APPEND_NOP  = 1'b1
) (
    input  logic                     clka,
    input  logic                     reset,
    input  logic [BYTE_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic                     reload,
    output logic                     we_ins,
    output logic [WORD_W-1:0]        load,
    output logic                     cpu_reset,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   word_count
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    loader_state_e     r_state,      w_state_n;
    logic [CNT_W-1:0]  r_word_count, w_word_count_n;
    logic [ADDR_W-1:0] r_rd,         w_rd_n;
    logic [HOLD_W-1:0] r_hold,       w_hold_n;
    logic [BYTE_W-1:0] r_hi,         w_hi_n;
    logic              r_phase_lo,   w_phase_lo_n;
    logic              r_overflow,   w_overflow_n;

    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [WORD_W-1:0] w_wr_data;
    logic [WORD_W-1:0] w_rd_data;

    logic              w_accept;
    logic              w_hold_end;
    logic              w_last_word;
    logic [CNT_W-1:0]  w_wc_inc;

    assign in_ready    = (r_state == ST_COLLECT) && !r_overflow;
    assign w_accept    = in_valid && in_ready;
    assign w_hold_end  = (r_hold == HOLD_W'(HOLD_CYCLES - 1));
    assign w_last_word = ({1'b0, r_rd} == (r_word_count - CNT_W'(1)));
    assign w_wc_inc    = (r_word_count == CNT_W'(DEPTH)) ? r_word_count
                                                         : r_word_count + CNT_W'(1);

    loader_word_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .i_clk     (clka),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (r_rd),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_COLLECT;
            r_word_count <= '0;
            r_rd         <= '0;
            r_hold       <= '0;
            r_hi         <= '0;
            r_phase_lo   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_word_count <= w_word_count_n;
            r_rd         <= w_rd_n;
            r_hold       <= w_hold_n;
            r_hi         <= w_hi_n;
            r_phase_lo   <= w_phase_lo_n;
            r_overflow   <= w_overflow_n;
        end
    end

    // Next-state, byte packing and replay counters.
    always_comb begin
        w_state_n      = r_state;
        w_word_count_n = r_word_count;
        w_rd_n         = r_rd;
        w_hold_n       = r_hold;
        w_hi_n         = r_hi;
        w_phase_lo_n   = r_phase_lo;
        w_overflow_n   = r_overflow;
        w_wr_en        = 1'b0;
        w_wr_addr      = r_word_count[ADDR_W-1:0];
        w_wr_data      = {r_hi, in_data};

        case (r_state)
            ST_COLLECT: begin
                w_rd_n   = '0;
                w_hold_n = '0;
                if (w_accept) begin
                    if (!r_phase_lo) begin
                        if (in_last) begin
                            // A lone final high byte is padded with a zero low byte.
                            w_wr_en        = 1'b1;
                            w_wr_data      = {in_data, 8'h00};
                            w_word_count_n = w_wc_inc;
                            w_state_n      = ST_PLAY;
                        end else begin
                            w_hi_n       = in_data;
                            w_phase_lo_n = 1'b1;
                        end
                    end else begin
                        w_wr_en        = 1'b1;
                        w_word_count_n = w_wc_inc;
                        w_phase_lo_n   = 1'b0;
                        if (in_last) begin
                            w_state_n = ST_PLAY;
                        end else if (r_word_count == CNT_W'(DEPTH - 1)) begin
                            w_overflow_n = 1'b1;
                            w_state_n    = ST_PLAY;
                        end
                    end
                end
            end
            ST_PLAY: begin
                if (w_hold_end) begin
                    w_hold_n = '0;
                    if (w_last_word) begin
                        w_rd_n    = '0;
                        w_state_n = APPEND_NOP ? ST_NOP : ST_RESTART;
                    end else begin
                        w_rd_n = r_rd + ADDR_W'(1);
                    end
                end else begin
                    w_hold_n = r_hold + HOLD_W'(1);
                end
            end
            ST_NOP: begin
                if (w_hold_end) begin
                    w_hold_n  = '0;
                    w_state_n = ST_RESTART;
                end else begin
                    w_hold_n = r_hold + HOLD_W'(1);
                end
            end
            ST_RESTART: begin
                w_state_n = ST_RUN;
            end
            ST_RUN: begin
                if (reload) begin
                    w_state_n      = ST_COLLECT;
                    w_word_count_n = '0;
                    w_overflow_n   = 1'b0;
                    w_phase_lo_n   = 1'b0;
                end
            end
            default: begin
                w_state_n = ST_COLLECT;
            end
        endcase
    end

    // Moore decode of the CPU-facing controls.
    always_comb begin
        we_ins    = 1'b0;
        load      = '0;
        cpu_reset = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                cpu_reset = 1'b1;
            end
            ST_PLAY: begin
                we_ins = 1'b1;
                load   = w_rd_data;
                busy   = 1'b1;
            end
            ST_NOP: begin
                we_ins = 1'b1;
                load   = NOP_WORD;
                busy   = 1'b1;
            end
            ST_RESTART: begin
                cpu_reset = 1'b1;
                busy      = 1'b1;
            end
            ST_RUN: begin
                done = 1'b1;
            end
            default: begin
                cpu_reset = 1'b1;
            end
        endcase
    end

    assign overflow   = r_overflow;
    assign word_count = r_word_count;

endmodule : program_loader
